// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//   Round-robin arbiter sharing one registered output channel between N_REQ
//   requesters. Every side uses valid/ready handshakes. The one-hot grant
//   steers an AND-OR mux tree into a single output register. Sustains one
//   transfer per cycle while the consumer stays ready.
//
// Ports
//   clk        in   1              clock, rising edge
//   rst_n      in   1              asynchronous active-low reset
//   req_valid  in   N_REQ          per-requester valid
//   req_data   in   N_REQ*W        requester i data on bits [i*W +: W]
//   req_ready  out  N_REQ          per-requester ready (one-hot or zero)
//   out_valid  out  1              output register holds a word
//   out_data   out  W              output word
//   out_src    out  clog2(N_REQ)   requester index that produced out_data
//   out_ready  in   1              consumer accepts out_data
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_REQ-1:0]                    req_valid,
  input  logic [N_REQ*W-1:0]                  req_data,
  output logic [N_REQ-1:0]                    req_ready,
  output logic                                out_valid,
  output logic [W-1:0]                        out_data,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] out_src,
  input  logic                                out_ready
);

  localparam int unsigned SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [SW-1:0]  ptr_q, ptr_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [SW-1:0]  out_src_q, out_src_d;

  logic [N_REQ-1:0] grant_c;
  logic [SW-1:0]    win_idx_c;
  logic             any_valid_c;
  logic [W-1:0]     data_mux_c;
  logic             load_ok_c;
  logic             accept_c;

  // Round-robin scan starting at ptr_q, wrapping once around the requesters.
  always_comb begin
    int unsigned idx;
    grant_c     = '0;
    win_idx_c   = '0;
    any_valid_c = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_valid_c && req_valid[idx]) begin
        any_valid_c  = 1'b1;
        grant_c[idx] = 1'b1;
        win_idx_c    = SW'(idx);
      end
    end
  end

  // AND-OR mux tree steered by the one-hot grant.
  always_comb begin
    data_mux_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      data_mux_c = data_mux_c | (req_data[i*W +: W] & {W{grant_c[i]}});
    end
  end

  // Output register may load when empty or draining this cycle; nothing is
  // offered while reset is held so no handshake can slip through.
  assign load_ok_c = (state_q == S_EMPTY) || out_ready;
  assign accept_c  = any_valid_c && load_ok_c && rst_n;
  assign req_ready = grant_c & {N_REQ{load_ok_c && rst_n}};

  // Next-state and datapath-next logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;

    if (accept_c) begin
      out_data_d = data_mux_c;
      out_src_d  = win_idx_c;
      ptr_d      = (32'(win_idx_c) == N_REQ - 1) ? '0 : SW'(32'(win_idx_c) + 1);
    end

    case (state_q)
      S_EMPTY: begin
        if (accept_c) state_d = S_FULL;
      end
      S_FULL: begin
        if (out_ready && !accept_c) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      ptr_q      <= '0;
      out_data_q <= '0;
      out_src_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter
//   Self-checking bench for rr_mux_arbiter (N_REQ=4, W=8). A behavioural model
//   (pointer, held word, valid flag) predicts req_ready and the output channel
//   every cycle; scenario tasks add directed expectations on top.
// ---------------------------------------------------------------------------
module tb_rr_mux_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [SW-1:0]    out_src;
  logic             out_ready;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int       m_ptr;
  bit       m_valid;
  bit [7:0] m_data;
  int       m_src;
  int       last_grant;

  rr_mux_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_winner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = 0; m_src = 0; last_grant = -1;
  endtask

  // One clock cycle: compare DUT against the model, cross the edge, advance
  // the model. Called with inputs already driven just after a falling edge.
  task automatic run_cycle(input string tag);
    logic [N-1:0] exp_rdy;
    int w;
    #1;
    w = model_winner(req_valid, m_ptr);
    exp_rdy = '0;
    if (w >= 0 && (!m_valid || out_ready)) exp_rdy[w] = 1'b1;
    checks++;
    if (req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL %s req_ready got=%b exp=%b", tag, req_ready, exp_rdy);
    end
    checks++;
    if (out_valid !== m_valid || out_data !== m_data || out_src !== SW'(m_src)) begin
      errors++;
      $display("FAIL %s out got v=%b d=%h s=%0d exp v=%b d=%h s=%0d",
               tag, out_valid, out_data, out_src, m_valid, m_data, m_src);
    end
    @(posedge clk);
    if (exp_rdy != '0) begin
      m_data = req_data[w*W +: W];
      m_src  = w;
      m_valid = 1;
      m_ptr  = (w + 1) % N;
      last_grant = w;
    end else begin
      last_grant = -1;
      if (out_ready) m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_data_random();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // Load a word so the output is FULL, then reset asynchronously mid-cycle.
    req_valid = 4'b0010; set_data_random(); out_ready = 1'b0;
    run_cycle("rst_fill");
    req_valid = 4'b1111;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async got v=%b d=%h s=%0d rdy=%b exp all zero",
               out_valid, out_data, out_src, req_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant got=%b exp=0001", req_ready);
    end
    run_cycle("rst_after");
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_data = '0; req_data[2*W +: W] = 8'hA5; out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready got=%b exp=0100", req_ready);
    end
    run_cycle("single");
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd2) begin
      errors++;
      $display("FAIL single_out got v=%b d=%h s=%0d exp v=1 d=a5 s=2", out_valid, out_data, out_src);
    end
    // ptr=3 shows up as the next grant with everybody requesting.
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL single_ptr got=%b exp=1000", req_ready);
    end
    run_cycle("single_next");
  endtask

  task automatic test_rotate();
    int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      set_data_random();
      run_cycle("rotate");
      checks++;
      if (out_valid !== 1'b1 || out_src !== SW'(exp_seq[c])) begin
        errors++;
        $display("FAIL rotate_seq[%0d] got v=%b s=%0d exp v=1 s=%0d", c, out_valid, out_src, exp_seq[c]);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] held_d;
    logic [SW-1:0] held_s;
    do_reset();
    req_valid = 4'b1111; set_data_random(); out_ready = 1'b1;
    run_cycle("bp_fill");
    held_d = m_data; held_s = SW'(m_src);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_data_random();
      run_cycle("bp_stall");
      checks++;
      if (out_data !== held_d || out_src !== held_s || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold got d=%h s=%0d exp d=%h s=%0d", out_data, out_src, held_d, held_s);
      end
    end
    out_ready = 1'b1;
    run_cycle("bp_release");
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd1) begin
      errors++;
      $display("FAIL bp_reload got v=%b s=%0d exp v=1 s=1", out_valid, out_src);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req_valid = 4'b0100; set_data_random(); out_ready = 1'b1;
    run_cycle("wrap_setptr");
    req_valid = 4'b1001;
    run_cycle("wrap_a");
    checks++;
    if (out_src !== 2'd3) begin
      errors++;
      $display("FAIL wrap_first got=%0d exp=3", out_src);
    end
    run_cycle("wrap_b");
    checks++;
    if (out_src !== 2'd0) begin
      errors++;
      $display("FAIL wrap_second got=%0d exp=0", out_src);
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_ptr got=%b exp=0010", req_ready);
    end
    run_cycle("wrap_c");
  endtask

  task automatic test_empty_cycle();
    do_reset();
    req_valid = 4'b0001; set_data_random(); out_ready = 1'b1;
    run_cycle("empty_fill");
    req_valid = 4'b0000;
    run_cycle("empty_drain");
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_drop got v=%b exp v=0", out_valid);
    end
    run_cycle("empty_idle");
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL empty_ptr got=%b exp=0010", req_ready);
    end
    run_cycle("empty_next");
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      set_data_random();
      out_ready = ($urandom_range(0, 3) != 0);
      run_cycle("random");
    end
  endtask

  initial begin
    model_reset();
    do_reset();
    test_reset();
    test_single();
    test_rotate();
    test_back_pressure();
    test_wrap();
    test_empty_cycle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
